uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
- REQ-001: The module SHALL have parameter WIDTH, default 8, giving the data bits per frame.
- REQ-002: The module SHALL have parameter DIVISOR, default 86, giving clk cycles per bit; it SHALL be even and at least 4.
- REQ-003: Port clk, input, 1 bit: the single clock; all logic SHALL run on its rising edge.
- REQ-004: Port i_reset_n, input, 1 bit: asynchronous, active-low reset.
- REQ-005: Port i_rx, input, 1 bit: asynchronous serial line, idle high.
- REQ-006: Port o_data, output, WIDTH bits: last correctly framed received word.
- REQ-007: Port o_dv, output, 1 bit: one-cycle strobe marking o_data valid and new.
- REQ-008: Port o_frame_err, output, 1 bit: one-cycle strobe when a frame's stop bit samples low.
- REQ-009: Port o_busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
- REQ-010: i_rx SHALL pass through a 2-flop synchronizer (rx_s) before any use; both flops reset to 1.
- REQ-011: The frame format SHALL be 1 start bit (0), then WIDTH data bits LSB first, then 1 stop bit (1); there is no parity.
- REQ-012: The FSM states SHALL be IDLE, START, DATA and STOP.
- REQ-013: IDLE -> START on the cycle rx_s=0 while the previous rx_s=1 (falling edge, call it cycle T); the bit counter clears.
- REQ-014: A low level present at reset release, or persisting after a frame, SHALL NOT start a frame; a high-to-low edge is required.
- REQ-015: START SHALL sample rx_s at T+DIVISOR/2 (mid start bit).
- REQ-016: If that start sample is 0, the FSM SHALL go to DATA.
- REQ-017: If that start sample is 1, the event is a glitch: the FSM SHALL return to IDLE with no strobe.
- REQ-018: DATA SHALL sample bit k (k=0..WIDTH-1) at T+DIVISOR/2+(k+1)*DIVISOR and shift it into the shift register at position MSB, so that bit 0 ends at the LSB.
- REQ-019: After bit WIDTH-1 is sampled, the FSM SHALL go to STOP.
- REQ-020: STOP SHALL sample at S=T+DIVISOR/2+(WIDTH+1)*DIVISOR.
- REQ-021: On a stop sample of 1: o_data <= shift register, and o_dv SHALL be high for exactly cycle S+1.
- REQ-022: On a stop sample of 0: o_frame_err SHALL be high for exactly cycle S+1, and o_data SHALL hold its previous value.
- REQ-023: After either stop outcome, the FSM SHALL go to IDLE at S+1.
- REQ-024: Latency from the i_rx falling edge to o_dv SHALL be 2 (sync) + DIVISOR/2 + (WIDTH+1)*DIVISOR + 1 cycles, ±1 for input edge phase.
- REQ-025: The cycle counter SHALL be wide enough for DIVISOR-1 ($clog2(DIVISOR)) and SHALL clear on every state transition.
- REQ-026: The bit index SHALL count 0..WIDTH-1 with no wrap beyond WIDTH-1.
- REQ-027: A falling edge arriving on the same cycle the FSM enters IDLE (back-to-back frames) SHALL be detected and start a new frame.
- REQ-028: o_dv and o_frame_err SHALL never be high in the same cycle.
- REQ-029: There is no receive flow control: o_data SHALL be overwritten by the next good frame regardless of the consumer.

Reset
- REQ-030: While i_reset_n=0, regardless of the current state: FSM=IDLE, counters=0, shift register=0, o_data=0, o_dv=0, o_frame_err=0, o_busy=0, sync flops=1.
- REQ-031: Reset asserted mid-frame SHALL abort the frame with no strobe.
- REQ-032: After reset release, the first frame SHALL be received only on a new falling edge.

Verification (DIVISOR=86, WIDTH=8, 10 MHz clk)
- REQ-033: Drive frame 0xA5, bit period 8600 ns -> exactly one o_dv pulse, o_data=0xA5, o_frame_err never high, o_busy falls the same cycle as o_dv.
- REQ-034: Drive i_rx low for 20 clk then high -> no o_dv, no o_frame_err, o_busy high ≤45 cycles then low.
- REQ-035: Drive 0x3C with stop bit forced low -> o_frame_err single pulse, o_dv never, o_data keeps its prior value (0xA5).
- REQ-036: Drive 0x00 then 0xFF back-to-back with zero idle gap -> two o_dv pulses, o_data=0x00 then 0xFF, spaced 860 cycles.
- REQ-037: Assert i_reset_n=0 during data bit 3 of 0x5A, release, then send 0x81 -> no strobe for 0x5A, one o_dv with o_data=0x81.
- REQ-038: Hold i_rx low through reset release, then raise it and send 0x42 -> no strobe until 0x42, then o_data=0x42.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized input, mid-bit sampling, 1 start / WIDTH data / 1 stop.
// Emits a one-cycle o_dv on a good frame or o_frame_err on a low stop bit.
module uart_rx #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DIVISOR = 86
) (
  input  logic             clk,
  input  logic             i_reset_n,
  input  logic             i_rx,
  output logic [WIDTH-1:0] o_data,
  output logic             o_dv,
  output logic             o_frame_err,
  output logic             o_busy
);

  localparam int unsigned CntW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] HalfLast = CntW'(DIVISOR / 2 - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(DIVISOR - 1);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e           state_q, state_d;
  logic             rx_meta_q, rx_s_q, rx_prev_q;
  logic [1:0]       sync_vld_q;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             dv_q, dv_d;
  logic             ferr_q, ferr_d;
  logic             fall, samp_start, samp_bit;

  // rx_prev_q only goes high from a real post-reset sample, so a line held low across
  // reset release never looks like a falling edge.
  assign fall       = rx_prev_q & ~rx_s_q;
  assign samp_start = (state_q == StStart) && (cnt_q == HalfLast);
  assign samp_bit   = ((state_q == StData) || (state_q == StStop)) && (cnt_q == BitLast);

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (fall) state_d = StStart;
      StStart: if (samp_start) state_d = rx_s_q ? StIdle : StData;
      StData:  if (samp_bit && (idx_q == IdxLast)) state_d = StStop;
      StStop:  if (samp_bit) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    ferr_d  = 1'b0;
    if ((state_d != state_q) || (state_q == StIdle) || samp_bit) begin
      cnt_d = '0;
    end
    if (state_q == StIdle) begin
      idx_d = '0;
    end
    if ((state_q == StData) && samp_bit) begin
      shift_d = {rx_s_q, shift_q[WIDTH-1:1]};
      if (idx_q != IdxLast) idx_d = idx_q + 1'b1;
    end
    if ((state_q == StStop) && samp_bit) begin
      if (rx_s_q) begin
        data_d = shift_q;
        dv_d   = 1'b1;
      end else begin
        ferr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      sync_vld_q <= '0;
      rx_prev_q  <= 1'b0;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      dv_q       <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      rx_meta_q  <= i_rx;
      rx_s_q     <= rx_meta_q;
      sync_vld_q <= {sync_vld_q[0], 1'b1};
      rx_prev_q  <= sync_vld_q[1] & rx_s_q;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      dv_q       <= dv_d;
      ferr_q     <= ferr_d;
    end
  end

  assign o_data      = data_q;
  assign o_dv        = dv_q;
  assign o_frame_err = ferr_q;
  assign o_busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of single frames plus glitch, back-to-back and reset cases.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned DIVISOR = 86;
  localparam int          LAT     = 2 + DIVISOR / 2 + (WIDTH + 1) * DIVISOR + 1;

  logic             clk;
  logic             i_reset_n;
  logic             i_rx;
  logic [WIDTH-1:0] o_data;
  logic             o_dv;
  logic             o_frame_err;
  logic             o_busy;

  uart_rx #(.WIDTH(WIDTH), .DIVISOR(DIVISOR)) dut (
    .clk         (clk),
    .i_reset_n   (i_reset_n),
    .i_rx        (i_rx),
    .o_data      (o_data),
    .o_dv        (o_dv),
    .o_frame_err (o_frame_err),
    .o_busy      (o_busy)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: owns all event counters; the test reads deltas.
  int         dv_total = 0;
  int         fe_total = 0;
  int         busy_total = 0;
  int         both_seen = 0;
  int         dv_busy_bad = 0;
  logic       prev_busy = 1'b0;
  logic [7:0] dv_data_log[$];
  int         dv_cyc_log[$];

  always @(negedge clk) begin
    if (o_dv) begin
      dv_total++;
      dv_data_log.push_back(o_data);
      dv_cyc_log.push_back(cyc);
      if (o_busy || !prev_busy) dv_busy_bad++;
    end
    if (o_frame_err) fe_total++;
    if (o_dv && o_frame_err) both_seen++;
    if (o_busy) busy_total++;
    prev_busy = o_busy;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Called at a negedge; drives start, data LSB first, stop; returns start cycle.
  task automatic send_frame(input logic [7:0] d, input logic stop, output int t0);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    t0 = cyc;
    for (int i = 0; i < 10; i++) begin
      i_rx = bits[i];
      repeat (DIVISOR) @(negedge clk);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_dv;
    int         exp_fe;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int t0, t1, dv0, fe0, b0, n0, lat;
    logic [31:0] v0, v1;

    vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
    vecs[1] = '{8'h3C, 1'b0, 0, 1, 8'hA5};
    vecs[2] = '{8'h00, 1'b1, 1, 0, 8'h00};
    vecs[3] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
    vecs[4] = '{8'h01, 1'b1, 1, 0, 8'h01};
    vecs[5] = '{8'h80, 1'b1, 1, 0, 8'h80};
    vecs[6] = '{8'hC3, 1'b0, 0, 1, 8'h80};

    i_rx = 1'b1;
    i_reset_n = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_data", o_data, 0);
    check("rst_dv", o_dv, 0);
    check("rst_ferr", o_frame_err, 0);
    check("rst_busy", o_busy, 0);
    i_reset_n = 1'b1;
    repeat (10) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      dv0 = dv_total; fe0 = fe_total; n0 = dv_cyc_log.size();
      send_frame(vecs[i].data, vecs[i].stop, t0);
      i_rx = 1'b1;
      repeat (2 * DIVISOR) @(negedge clk);
      check($sformatf("vec%0d_dv", i), dv_total - dv0, vecs[i].exp_dv);
      check($sformatf("vec%0d_fe", i), fe_total - fe0, vecs[i].exp_fe);
      check($sformatf("vec%0d_data", i), o_data, vecs[i].exp_data);
      if (vecs[i].exp_dv == 1) begin
        lat = (dv_cyc_log.size() > n0) ? dv_cyc_log[n0] - t0 : -1;
        check_rng($sformatf("vec%0d_lat", i), lat, LAT - 1, LAT + 1);
      end
    end

    // Short low pulse: start sample sees high, frame abandoned.
    dv0 = dv_total; fe0 = fe_total; b0 = busy_total;
    i_rx = 1'b0;
    repeat (20) @(negedge clk);
    i_rx = 1'b1;
    repeat (200) @(negedge clk);
    check("glitch_dv", dv_total - dv0, 0);
    check("glitch_fe", fe_total - fe0, 0);
    check_rng("glitch_busy_cycles", busy_total - b0, 42, 45);
    check("glitch_busy_end", o_busy, 0);

    // Back-to-back frames with no idle between stop and next start.
    dv0 = dv_total; n0 = dv_cyc_log.size();
    send_frame(8'h00, 1'b1, t0);
    send_frame(8'hFF, 1'b1, t1);
    i_rx = 1'b1;
    repeat (2 * DIVISOR) @(negedge clk);
    check("b2b_dv", dv_total - dv0, 2);
    v0 = (dv_data_log.size() > n0) ? 32'(dv_data_log[n0]) : 32'hFFFF_FFFF;
    v1 = (dv_data_log.size() > n0 + 1) ? 32'(dv_data_log[n0 + 1]) : 32'hFFFF_FFFF;
    check("b2b_first", v0, 32'h00);
    check("b2b_second", v1, 32'hFF);
    lat = (dv_cyc_log.size() > n0 + 1) ? dv_cyc_log[n0 + 1] - dv_cyc_log[n0] : -1;
    check("b2b_spacing", lat, 10 * DIVISOR);

    // Reset in the middle of data bit 3 of 0x5A (bits 0..3 = 0,1,0,1).
    dv0 = dv_total; fe0 = fe_total;
    i_rx = 1'b0; repeat (DIVISOR) @(negedge clk);
    i_rx = 1'b0; repeat (DIVISOR) @(negedge clk);
    i_rx = 1'b1; repeat (DIVISOR) @(negedge clk);
    i_rx = 1'b0; repeat (DIVISOR) @(negedge clk);
    i_rx = 1'b1; repeat (DIVISOR / 2) @(negedge clk);
    check("mid_busy_before_rst", o_busy, 1);
    i_reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_data", o_data, 0);
    i_reset_n = 1'b1;
    repeat (2 * DIVISOR) @(negedge clk);
    send_frame(8'h81, 1'b1, t0);
    i_rx = 1'b1;
    repeat (2 * DIVISOR) @(negedge clk);
    check("mid_dv", dv_total - dv0, 1);
    check("mid_fe", fe_total - fe0, 0);
    check("mid_data", o_data, 8'h81);

    // Line held low across reset release must not start a frame.
    dv0 = dv_total; fe0 = fe_total; b0 = busy_total;
    i_rx = 1'b0;
    i_reset_n = 1'b0;
    repeat (3) @(negedge clk);
    i_reset_n = 1'b1;
    repeat (300) @(negedge clk);
    check("lowrel_busy", busy_total - b0, 0);
    check("lowrel_dv", dv_total - dv0, 0);
    i_rx = 1'b1;
    repeat (DIVISOR) @(negedge clk);
    send_frame(8'h42, 1'b1, t0);
    i_rx = 1'b1;
    repeat (2 * DIVISOR) @(negedge clk);
    check("lowrel_dv_after", dv_total - dv0, 1);
    check("lowrel_fe", fe_total - fe0, 0);
    check("lowrel_data", o_data, 8'h42);

    check("dv_ferr_overlap", both_seen, 0);
    check("dv_busy_fall", dv_busy_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
